mem_access_ctrl: RTL and testbench

//  Handshake front end for the single-port memory (en/wr/addr/w_data, combinational r_data).

---
 rtl/mem_access_ctrl.sv | 130 +++++++++++++
 tb/tb_mem_access_ctrl.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_ctrl.sv
// Handshake front end for a single-port memory with combinational read data.
// It accepts burst commands, streams write beats into the memory, and returns read beats through a 1-entry registered buffer.
module mem_access_ctrl #(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 64,
  parameter int LEN_W  = 4,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_wr,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic              wd_valid,
  output logic              wd_ready,
  input  logic [WIDTH-1:0]  wd_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [WIDTH-1:0]  rd_data,
  output logic              rd_last,
  output logic              busy,
  output logic              mem_en,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WIDTH-1:0]  mem_wdata,
  input  logic [WIDTH-1:0]  mem_rdata
);

  typedef enum logic [1:0] {IDLE, WRITE, READ} state_t;

  localparam logic [ADDR_W-1:0] ADDR_MAX = ADDR_W'(DEPTH - 1);

  state_t            state, state_next;
  logic [ADDR_W-1:0] addr;
  logic [LEN_W-1:0]  cnt;
  logic [LEN_W-1:0]  len;
  logic              beat;
  logic              rd_issue;
  logic              last;
  logic              cmd_accept;

  // NOTE: every output of this block gets a default first, so no path can leave one unassigned and infer a latch.
  always_comb begin
    state_next = state;
    cmd_ready  = 1'b0;
    wd_ready   = 1'b0;
    beat       = 1'b0;
    rd_issue   = 1'b0;
    mem_en     = 1'b0;
    mem_wr     = 1'b0;
    last       = (cnt == len);
    unique case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) state_next = cmd_wr ? WRITE : READ;
      end
      WRITE: begin
        wd_ready = 1'b1;
        if (wd_valid) begin
          beat   = 1'b1;
          mem_en = 1'b1;
          mem_wr = 1'b1;
          if (last) state_next = IDLE;
        end
      end
      READ: begin
        // A beat is issued only when the output buffer is empty or is being popped this cycle.
        if (!rd_valid || rd_ready) begin
          beat     = 1'b1;
          rd_issue = 1'b1;
          mem_en   = 1'b1;
          if (last) state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
    // Reset takes priority, so a beat coinciding with reset never reaches the memory.
    if (rst) begin
      cmd_ready = 1'b0;
      wd_ready  = 1'b0;
      beat      = 1'b0;
      rd_issue  = 1'b0;
      mem_en    = 1'b0;
      mem_wr    = 1'b0;
    end
  end

  assign cmd_accept = cmd_ready && cmd_valid;
  assign mem_addr   = rst ? '0 : addr;
  assign mem_wdata  = rst ? '0 : wd_data;
  assign busy       = (state != IDLE) || rd_valid;

  // NOTE: sequential state is assigned non-blocking so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr <= '0;
      cnt  <= '0;
      len  <= '0;
    end else if (cmd_accept) begin
      addr <= cmd_addr;
      len  <= cmd_len;
      cnt  <= '0;
    end else if (beat) begin
      addr <= (addr == ADDR_MAX) ? '0 : addr + ADDR_W'(1);
      cnt  <= cnt + LEN_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
      rd_last  <= 1'b0;
    end else if (rd_issue) begin
      rd_valid <= 1'b1;
      rd_data  <= mem_rdata;
      rd_last  <= last;
    end else if (rd_ready) begin
      rd_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: a behavioural memory sits behind the DUT,
// and expected read beats are queued when a read command is sent and compared as they pop.
module tb_mem_access_ctrl;

  localparam int WIDTH  = 8;
  localparam int DEPTH  = 64;
  localparam int LEN_W  = 4;
  localparam int ADDR_W = 6;

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic             last;
  } beat_t;

  logic              clk = 1'b0;
  logic              rst;
  logic              cmd_valid, cmd_ready, cmd_wr;
  logic [ADDR_W-1:0] cmd_addr;
  logic [LEN_W-1:0]  cmd_len;
  logic              wd_valid, wd_ready;
  logic [WIDTH-1:0]  wd_data;
  logic              rd_valid, rd_ready, rd_last;
  logic [WIDTH-1:0]  rd_data;
  logic              busy, mem_en, mem_wr;
  logic [ADDR_W-1:0] mem_addr;
  logic [WIDTH-1:0]  mem_wdata, mem_rdata;

  logic [WIDTH-1:0] mem     [DEPTH];
  logic [WIDTH-1:0] ref_mem [DEPTH];
  beat_t            sb[$];
  int               n_pass  = 0;
  int               n_total = 0;
  bit               stall_chk = 1'b0;

  always #5 clk = ~clk;

  mem_access_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wd_valid(wd_valid), .wd_ready(wd_ready), .wd_data(wd_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last),
    .busy(busy), .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always @(posedge clk) if (mem_en && mem_wr) mem[mem_addr] <= mem_wdata;
  assign mem_rdata = mem[mem_addr];

  // Read-beat monitor: every handshake pops one expected beat.
  always @(negedge clk) begin
    beat_t exp;
    #2;
    if (!rst && rd_valid && rd_ready) begin
      n_total++;
      if (sb.size() == 0) begin
        $display("FAIL rd_beat_unexpected: got data=%h last=%b, required no beat", rd_data, rd_last);
      end else begin
        exp = sb.pop_front();
        if (rd_data !== exp.data || rd_last !== exp.last)
          $display("FAIL rd_beat: got data=%h last=%b, required data=%h last=%b",
                   rd_data, rd_last, exp.data, exp.last);
        else n_pass++;
      end
    end
    if (stall_chk && !rst && rd_valid && !rd_ready) begin
      n_total++;
      if (mem_en !== 1'b0) $display("FAIL stall_no_issue: got mem_en=%b, required 0", mem_en);
      else n_pass++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic idle_inputs();
    cmd_valid = 1'b0; cmd_wr = 1'b0; cmd_addr = '0; cmd_len = '0;
    wd_valid  = 1'b0; wd_data = '0; rd_ready = 1'b0;
  endtask

  task automatic do_reset(input int cyc);
    @(negedge clk);
    rst = 1'b1;
    idle_inputs();
    repeat (cyc) @(negedge clk);
    rst = 1'b0;
    sb.delete();
  endtask

  // Presents a command and returns at the first negedge after acceptance, with cmd_valid dropped.
  task automatic send_cmd(input bit wr, input logic [ADDR_W-1:0] a, input logic [LEN_W-1:0] l);
    int w = 0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_wr = wr; cmd_addr = a; cmd_len = l;
    #1;
    while (!cmd_ready && w < 50) begin
      @(negedge clk); #1; w++;
    end
    n_total++;
    if (cmd_ready !== 1'b1) $display("FAIL cmd_accept_timeout: got cmd_ready=%b, required 1", cmd_ready);
    else n_pass++;
    if (!wr)
      for (int i = 0; i <= int'(l); i++)
        sb.push_back('{data: ref_mem[a + ADDR_W'(i)], last: (i == int'(l))});
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  // pat bit k = wd_valid in cycle k; data of the j-th fired beat is base+j.
  task automatic write_burst(input logic [ADDR_W-1:0] a, input logic [LEN_W-1:0] l,
                             input logic [WIDTH-1:0] base, input logic [15:0] pat, input int ncyc);
    logic [ADDR_W-1:0] wa = a;
    logic [WIDTH-1:0]  d;
    int j = 0;
    send_cmd(1'b1, a, l);
    for (int k = 0; k < ncyc; k++) begin
      if (k > 0) @(negedge clk);
      d        = base + WIDTH'(j);
      wd_valid = pat[k];
      wd_data  = pat[k] ? d : 8'hEE;
      #1;
      n_total++;
      if (cmd_ready !== 1'b0 || wd_ready !== 1'b1)
        $display("FAIL wr_handshake: got cmd_ready=%b wd_ready=%b, required 0 1", cmd_ready, wd_ready);
      else n_pass++;
      n_total++;
      if (mem_en !== pat[k] || mem_wr !== pat[k])
        $display("FAIL wr_mem_en: got en=%b wr=%b, required %b %b", mem_en, mem_wr, pat[k], pat[k]);
      else n_pass++;
      if (pat[k]) begin
        n_total++;
        if (mem_addr !== wa || mem_wdata !== d)
          $display("FAIL wr_beat: got addr=%0d data=%h, required addr=%0d data=%h", mem_addr, mem_wdata, wa, d);
        else n_pass++;
        ref_mem[wa] = d;
        wa = wa + 1'b1;
        j++;
      end
    end
    @(negedge clk);
    wd_valid = 1'b0;
    #1;
    n_total++;
    if (cmd_ready !== 1'b1 || wd_ready !== 1'b0 || mem_en !== 1'b0)
      $display("FAIL wr_end_idle: got cmd_ready=%b wd_ready=%b mem_en=%b, required 1 0 0", cmd_ready, wd_ready, mem_en);
    else n_pass++;
  endtask

  // Drains the scoreboard; mode 0 holds rd_ready high, mode 1 toggles it pseudo-randomly.
  task automatic drain(input int mode);
    for (int c = 0; c < 300; c++) begin
      rd_ready = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      #3;
      if (sb.size() == 0) break;
      @(negedge clk);
    end
    n_total++;
    if (sb.size() != 0) $display("FAIL rd_drain_timeout: got %0d beats outstanding, required 0", sb.size());
    else n_pass++;
    @(negedge clk);
    rd_ready = 1'b0;
    #1;
    n_total++;
    if (rd_valid !== 1'b0 || busy !== 1'b0)
      $display("FAIL rd_end_idle: got rd_valid=%b busy=%b, required 0 0", rd_valid, busy);
    else n_pass++;
  endtask

  task automatic test_reset();
    do_reset(2);
    #1;
    n_total++;
    if (rd_valid !== 1'b0 || rd_data !== '0 || rd_last !== 1'b0)
      $display("FAIL reset_rd: got valid=%b data=%h last=%b, required 0 00 0", rd_valid, rd_data, rd_last);
    else n_pass++;
    n_total++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0)
      $display("FAIL reset_idle: got cmd_ready=%b busy=%b, required 1 0", cmd_ready, busy);
    else n_pass++;
    n_total++;
    if (mem_en !== 1'b0 || mem_wr !== 1'b0 || mem_addr !== '0)
      $display("FAIL reset_mem: got en=%b wr=%b addr=%0d, required 0 0 0", mem_en, mem_wr, mem_addr);
    else n_pass++;
  endtask

  task automatic test_single();
    write_burst(6'd5, 4'd0, 8'hA5, 16'h1, 1);
    send_cmd(1'b0, 6'd5, 4'd0);
    rd_ready = 1'b1;
    #1;
    n_total++;
    if (mem_en !== 1'b1 || mem_wr !== 1'b0 || mem_addr !== 6'd5 || rd_valid !== 1'b0)
      $display("FAIL single_issue: got en=%b wr=%b addr=%0d rd_valid=%b, required 1 0 5 0",
               mem_en, mem_wr, mem_addr, rd_valid);
    else n_pass++;
    @(negedge clk);
    #1;
    n_total++;
    if (rd_valid !== 1'b1 || busy !== 1'b1)
      $display("FAIL single_latency: got rd_valid=%b busy=%b, required 1 1", rd_valid, busy);
    else n_pass++;
    drain(0);
  endtask

  task automatic test_wrap();
    write_burst(6'd62, 4'd3, 8'd1, 16'hF, 4);
    n_total++;
    if (mem[62] !== 8'd1 || mem[63] !== 8'd2 || mem[0] !== 8'd3 || mem[1] !== 8'd4)
      $display("FAIL wrap_mem: got %h %h %h %h, required 01 02 03 04", mem[62], mem[63], mem[0], mem[1]);
    else n_pass++;
    send_cmd(1'b0, 6'd62, 4'd3);
    drain(0);
  endtask

  task automatic test_backpressure();
    write_burst(6'd20, 4'd7, 8'h30, 16'hFF, 8);
    stall_chk = 1'b1;
    send_cmd(1'b0, 6'd20, 4'd7);
    drain(1);
    stall_chk = 1'b0;
  endtask

  task automatic test_write_gaps();
    write_burst(6'd10, 4'd2, 8'h50, 16'b10_1001, 6);
    send_cmd(1'b0, 6'd10, 4'd2);
    drain(0);
  endtask

  task automatic test_back_to_back();
    send_cmd(1'b0, 6'd20, 4'd0);
    @(negedge clk);
    #1;
    n_total++;
    if (rd_valid !== 1'b1 || busy !== 1'b1 || cmd_ready !== 1'b1)
      $display("FAIL pending_idle: got rd_valid=%b busy=%b cmd_ready=%b, required 1 1 1", rd_valid, busy, cmd_ready);
    else n_pass++;
    send_cmd(1'b0, 6'd21, 4'd1);
    #1;
    n_total++;
    if (mem_en !== 1'b0 || rd_valid !== 1'b1)
      $display("FAIL pending_block: got mem_en=%b rd_valid=%b, required 0 1", mem_en, rd_valid);
    else n_pass++;
    drain(0);
  endtask

  task automatic test_reset_abort();
    send_cmd(1'b1, 6'd40, 4'd5);
    wd_valid = 1'b1; wd_data = 8'h77;
    #1;
    n_total++;
    if (mem_en !== 1'b1) $display("FAIL abort_beat1: got mem_en=%b, required 1", mem_en);
    else n_pass++;
    ref_mem[40] = 8'h77;
    @(negedge clk);
    rst = 1'b1; wd_data = 8'h78;
    #1;
    n_total++;
    if (mem_en !== 1'b0) $display("FAIL abort_beat2: got mem_en=%b, required 0", mem_en);
    else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_total++;
    if (cmd_ready !== 1'b1 || wd_ready !== 1'b0 || mem_en !== 1'b0 || busy !== 1'b0)
      $display("FAIL abort_wr_idle: got cmd_ready=%b wd_ready=%b mem_en=%b busy=%b, required 1 0 0 0",
               cmd_ready, wd_ready, mem_en, busy);
    else n_pass++;
    wd_valid = 1'b0;
    sb.delete();
    send_cmd(1'b0, 6'd20, 4'd5);
    @(negedge clk);
    #1;
    n_total++;
    if (rd_valid !== 1'b1) $display("FAIL abort_rd_pending: got rd_valid=%b, required 1", rd_valid);
    else n_pass++;
    @(negedge clk);
    rst = 1'b1;
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_total++;
    if (rd_valid !== 1'b0 || rd_data !== '0 || cmd_ready !== 1'b1 || busy !== 1'b0 || mem_en !== 1'b0)
      $display("FAIL abort_rd_idle: got rd_valid=%b rd_data=%h cmd_ready=%b busy=%b mem_en=%b, required 0 00 1 0 0",
               rd_valid, rd_data, cmd_ready, busy, mem_en);
    else n_pass++;
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    for (int i = 0; i < DEPTH; i++) begin
      mem[i]     = '0;
      ref_mem[i] = '0;
    end
    test_reset();
    test_single();
    test_wrap();
    test_backpressure();
    test_write_gaps();
    test_back_to_back();
    test_reset_abort();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
